fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined MIPS-subset core. It sits directly upstream of the decoder and owns the program counter. It drives the instruction-memory address and captures the returned word into the IF/ID pipeline register. It accepts stall (hazard hold) and redirect (jump / jr / taken bne resolved downstream) requests, and keeps a fetch counter and a sticky misalignment flag for debug.

---
 rtl/fetch_stage.sv | 59 +++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, drives the instruction-memory
// address and registers the returned word into IF/ID. It also tracks debug counters.
module fetch_stage #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] instrAddr,
   input  logic [WIDTH-1:0] instrIn,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirectAddr,
   output logic             ifidValid,
   output logic [WIDTH-1:0] ifidInstr,
   output logic [WIDTH-1:0] ifidPc,
   output logic [WIDTH-1:0] ifidPcInc,
   output logic [WIDTH-1:0] fetchCount,
   output logic             misalignErr
);

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next_seq;
   logic [WIDTH-1:0] redirect_target;

   assign instrAddr       = pc;
   assign pc_next_seq     = pc + PC_STEP;
   // Targets are forced word-aligned; a misaligned request is only flagged.
   assign redirect_target = {redirectAddr[WIDTH-1:2], 2'b00};

   // Priority when not in reset: redirect > stall > advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         ifidValid   <= 1'b0;
         ifidInstr   <= '0;
         ifidPc      <= '0;
         ifidPcInc   <= '0;
         fetchCount  <= '0;
         misalignErr <= 1'b0;
      end else if (redirect) begin
         pc        <= redirect_target;
         ifidValid <= 1'b0;
         ifidInstr <= '0;
         if (redirectAddr[1:0] != 2'b00)
            misalignErr <= 1'b1;
      end else if (!stall) begin
         pc         <= pc_next_seq;
         ifidValid  <= 1'b1;
         ifidInstr  <= instrIn;
         ifidPc     <= pc;
         ifidPcInc  <= pc_next_seq;
         fetchCount <= fetchCount + WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, all compared against a cycle-level reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_addr;
   logic [31:0] instr_in;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_inc;
   logic [31:0] fetch_count;
   logic        misalign_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_ifpc, m_inc, m_count;
   logic        m_valid, m_err;

   always #5 clk = ~clk;

   fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .instrAddr    (instr_addr),
      .instrIn      (instr_in),
      .stall        (stall),
      .redirect     (redirect),
      .redirectAddr (redirect_addr),
      .ifidValid    (ifid_valid),
      .ifidInstr    (ifid_instr),
      .ifidPc       (ifid_pc),
      .ifidPcInc    (ifid_pc_inc),
      .fetchCount   (fetch_count),
      .misalignErr  (misalign_err)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
      endcase
   endfunction

   always_comb instr_in = mem_word(instr_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".instrAddr"},   instr_addr,          m_pc);
      chk({tag, ".ifidValid"},   {31'b0, ifid_valid}, {31'b0, m_valid});
      chk({tag, ".ifidInstr"},   ifid_instr,          m_instr);
      chk({tag, ".ifidPc"},      ifid_pc,             m_ifpc);
      chk({tag, ".ifidPcInc"},   ifid_pc_inc,         m_inc);
      chk({tag, ".fetchCount"},  fetch_count,         m_count);
      chk({tag, ".misalignErr"}, {31'b0, misalign_err}, {31'b0, m_err});
   endtask

   // One clock: apply inputs, let the edge happen, advance the model, compare.
   task automatic step(input string tag, input logic rst, input logic stl,
                       input logic rdr, input logic [31:0] addr);
      logic [31:0] word_seen;
      reset = rst; stall = stl; redirect = rdr; redirect_addr = addr;
      word_seen = mem_word(m_pc);
      @(posedge clk);
      if (rst) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0;
         m_inc = 32'h0; m_count = 32'h0; m_err = 1'b0;
      end else if (rdr) begin
         m_pc = addr - (addr % 4);
         m_valid = 1'b0; m_instr = 32'h0;
         if (addr % 4 != 0) m_err = 1'b1;
      end else if (!stl) begin
         m_instr = word_seen; m_ifpc = m_pc; m_inc = m_pc + 4;
         m_valid = 1'b1; m_pc = m_pc + 4; m_count = m_count + 1;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0;
      m_inc = 32'h0; m_count = 32'h0; m_err = 1'b0;

      step("reset", 1, 0, 0, 0);
      chk("reset_pc_lit", instr_addr, 32'h0);
      chk("reset_cnt_lit", fetch_count, 32'h0);

      // sequential fetch
      step("seq0", 0, 0, 0, 0);
      chk("seq0_instr_lit", ifid_instr, 32'h11);
      step("seq1", 0, 0, 0, 0);
      chk("seq1_instr_lit", ifid_instr, 32'h22);
      chk("seq1_inc_lit", ifid_pc_inc, 32'h8);

      // stall holds everything
      step("stall0", 0, 1, 0, 0);
      step("stall1", 0, 1, 0, 0);
      chk("stall_addr_lit", instr_addr, 32'h8);
      chk("stall_instr_lit", ifid_instr, 32'h22);
      step("seq2", 0, 0, 0, 0);
      chk("seq2_instr_lit", ifid_instr, 32'h33);
      chk("seq2_pc_lit", ifid_pc, 32'h8);
      chk("seq2_cnt_lit", fetch_count, 32'd3);
      chk("seq2_addr_lit", instr_addr, 32'd12);

      // redirect wins over stall, one bubble, then target word
      step("redir_stall", 0, 1, 1, 32'h40);
      chk("redir_valid_lit", {31'b0, ifid_valid}, 32'h0);
      chk("redir_addr_lit", instr_addr, 32'h40);
      step("redir_adv", 0, 0, 0, 0);
      chk("redir_adv_pc_lit", ifid_pc, 32'h40);

      // misaligned redirect is sticky until reset
      step("mis", 0, 0, 1, 32'h43);
      chk("mis_addr_lit", instr_addr, 32'h40);
      chk("mis_err_lit", {31'b0, misalign_err}, 32'h1);
      step("mis_norm", 0, 0, 1, 32'h80);
      step("mis_adv", 0, 0, 0, 0);

      // wrap at top of address space
      step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
      step("wrap_adv0", 0, 0, 0, 0);
      chk("wrap_inc_lit", ifid_pc_inc, 32'h0);
      chk("wrap_addr0_lit", instr_addr, 32'h0);
      step("wrap_adv1", 0, 0, 0, 0);
      chk("wrap_addr1_lit", instr_addr, 32'h4);

      // reset mid-operation together with redirect
      for (int i = 0; i < 5; i++) step("pre_rst", 0, 0, 0, 0);
      step("rst_redir", 1, 0, 1, 32'h123);
      chk("rst_cnt_lit", fetch_count, 32'h0);
      chk("rst_err_lit", {31'b0, misalign_err}, 32'h0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic        r_rst, r_stl, r_rdr;
         logic [31:0] r_addr;
         r_rst = ($urandom_range(0, 49) == 0);
         r_stl = ($urandom_range(0, 3) == 0);
         r_rdr = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       r_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            1:       r_addr = $urandom;
            default: r_addr = {$urandom_range(0, 255), 2'b00};
         endcase
         step("rand", r_rst, r_stl, r_rdr, r_addr);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
